// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - clip/pack raster pixels into a FIFO and drain them to the framebuffer port
module pixel_write_buffer #(
  parameter int DEPTH     = 16,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_BITS = 17
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_write_pixel,
  input  logic [15:0]            i_x,
  input  logic [15:0]            i_y,
  input  logic [7:0]             i_color_r,
  input  logic [7:0]             i_color_g,
  input  logic [7:0]             i_color_b,
  input  logic                   i_draw_done,
  output logic                   o_mem_req,
  output logic [ADDR_BITS-1:0]   o_mem_addr,
  output logic [15:0]            o_mem_data,
  input  logic                   i_mem_ack,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_almost_full,
  output logic                   o_overflow,
  output logic                   o_flush_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_BITS + 16;
  localparam logic [PW:0] FULL     = (PW+1)'(DEPTH);
  localparam logic [PW:0] AF_LEVEL = (PW+1)'(DEPTH - 4);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_next;

  logic [EW-1:0]        mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count, count_next;
  logic                 pending;
  logic                 in_range, push, pop, empty;
  logic [ADDR_BITS-1:0] pix_addr;
  logic [15:0]          pix_data;
  logic                 unused_color_bits;

  // Negative coordinates show up as bit 15 set; the unsigned compare handles the upper bound.
  assign in_range = i_write_pixel && !i_x[15] && !i_y[15]
                    && ({16'd0, i_x} < 32'(FB_WIDTH))
                    && ({16'd0, i_y} < 32'(FB_HEIGHT));
  assign pix_addr = ADDR_BITS'({16'd0, i_y} * 32'(FB_WIDTH) + {16'd0, i_x});
  assign pix_data = {i_color_r[7:3], i_color_g[7:2], i_color_b[7:3]};
  assign unused_color_bits = ^{i_color_r[2:0], i_color_g[1:0], i_color_b[2:0]};

  assign empty      = (count == '0);
  assign push       = in_range && (count != FULL);
  assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_mem_req    = (state == REQ);
  assign o_level      = count;
  assign o_flush_done = pending && empty && (state == IDLE) && !push;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {pix_addr, pix_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pending       <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_data    <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      o_almost_full <= (count_next >= AF_LEVEL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {o_mem_addr, o_mem_data} <= mem[rd_ptr];
        rd_ptr                   <= rd_ptr + 1'b1;
      end
      if (in_range && (count == FULL)) o_overflow <= 1'b1;
      // A draw_done landing in the flush cycle itself starts a fresh flush.
      pending <= i_draw_done || (pending && !o_flush_done);
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - scoreboard bench for pixel_write_buffer
module tb_pixel_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_pixel = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        draw_done = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic [15:0] mem_data;
  logic [4:0]  level;
  logic        almost_full, overflow, flush_done;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int flushes = 0;
  logic [32:0] sb [$];
  logic [32:0] mon_exp;

  always #5 clk = ~clk;

  pixel_write_buffer dut (
    .i_clk(clk), .i_reset(reset), .i_write_pixel(write_pixel),
    .i_x(x), .i_y(y), .i_color_r(r), .i_color_g(g), .i_color_b(b),
    .i_draw_done(draw_done), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .o_mem_data(mem_data), .i_mem_ack(mem_ack), .o_level(level),
    .o_almost_full(almost_full), .o_overflow(overflow), .o_flush_done(flush_done)
  );

  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected addr=%0d data=%h", mem_addr, mem_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({mem_addr, mem_data} !== mon_exp) begin
          failures++;
          $display("FAIL write_order got addr=%0d data=%h expected addr=%0d data=%h",
                   mem_addr, mem_data, mon_exp[32:16], mon_exp[15:0]);
        end
      end
      writes++;
    end
    if (!reset && flush_done) flushes++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input int px, input int py, input logic [7:0] pr,
                           input logic [7:0] pg, input logic [7:0] pb, input bit accept);
    write_pixel = 1'b1;
    x = px[15:0];
    y = py[15:0];
    r = pr; g = pg; b = pb;
    if (accept && px >= 0 && px < 320 && py >= 0 && py < 240)
      sb.push_back({17'(py * 320 + px), pr[7:3], pg[7:2], pb[7:3]});
  endtask

  task automatic idle_inputs;
    write_pixel = 1'b0;
    draw_done   = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    mem_ack = 1'b0;
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || mem_req || level != 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s_drain_timeout pending=%0d required=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 7;
    if (mem_req !== 1'b0)     begin failures++; $display("FAIL reset_req got=%b required=0", mem_req); end
    if (mem_addr !== 17'd0)   begin failures++; $display("FAIL reset_addr got=%0d required=0", mem_addr); end
    if (mem_data !== 16'd0)   begin failures++; $display("FAIL reset_data got=%h required=0", mem_data); end
    if (level !== 5'd0)       begin failures++; $display("FAIL reset_level got=%0d required=0", level); end
    if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b required=0", almost_full); end
    if (overflow !== 1'b0)    begin failures++; $display("FAIL reset_ovf got=%b required=0", overflow); end
    if (flush_done !== 1'b0)  begin failures++; $display("FAIL reset_flush got=%b required=0", flush_done); end
  endtask

  task automatic test_single;
    int w0 = writes;
    mem_ack = 1'b1;
    set_pixel(10, 2, 8'hFF, 8'h80, 8'h08, 1'b1);
    tick();
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL single_req_t1 got=%b required=0", mem_req); end
    write_pixel = 1'b0;
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    checks += 3;
    if (mem_req !== 1'b1)       begin failures++; $display("FAIL single_req_t2 got=%b required=1", mem_req); end
    if (mem_addr !== 17'd650)   begin failures++; $display("FAIL single_addr got=%0d required=650", mem_addr); end
    if (mem_data !== 16'hFC01)  begin failures++; $display("FAIL single_data got=%h required=fc01", mem_data); end
    tick();
    checks += 2;
    if (flush_done !== 1'b1) begin failures++; $display("FAIL single_flush got=%b required=1", flush_done); end
    if (mem_req !== 1'b0)    begin failures++; $display("FAIL single_req_t3 got=%b required=0", mem_req); end
    tick();
    checks += 2;
    if (flush_done !== 1'b0) begin failures++; $display("FAIL single_flush_end got=%b required=0", flush_done); end
    if (writes - w0 != 1)    begin failures++; $display("FAIL single_writes got=%0d required=1", writes - w0); end
  endtask

  task automatic test_clip;
    int w0 = writes;
    mem_ack = 1'b1;
    set_pixel(-1, 0, 8'h11, 8'h22, 8'h33, 1'b1);   tick();
    set_pixel(320, 5, 8'h11, 8'h22, 8'h33, 1'b1);  tick();
    set_pixel(0, 240, 8'h11, 8'h22, 8'h33, 1'b1);  tick();
    set_pixel(319, 239, 8'h12, 8'h34, 8'h56, 1'b1); tick();
    idle_inputs();
    wait_drain("clip");
    checks += 2;
    if (writes - w0 != 1)  begin failures++; $display("FAIL clip_writes got=%0d required=1", writes - w0); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL clip_ovf got=%b required=0", overflow); end
  endtask

  task automatic test_backpressure;
    int w0 = writes;
    int exp_level;
    mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pixel(i, 7, 8'(i * 8), 8'(255 - i * 8), 8'(i * 3), i < 17);
      tick();
      exp_level = (i == 0) ? 1 : ((i > 16) ? 16 : i);
      checks += 2;
      if (level !== 5'(exp_level)) begin
        failures++;
        $display("FAIL bp_level_%0d got=%0d required=%0d", i, level, exp_level);
      end
      if (almost_full !== (exp_level >= 12)) begin
        failures++;
        $display("FAIL bp_af_%0d got=%b required=%b", i, almost_full, exp_level >= 12);
      end
    end
    idle_inputs();
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b required=1", overflow); end
    mem_ack = 1'b1;
    wait_drain("bp");
    checks++;
    if (writes - w0 != 17) begin failures++; $display("FAIL bp_writes got=%0d required=17", writes - w0); end
  endtask

  task automatic test_throttle;
    int w0, f0;
    logic prev_req, prev_ack;
    logic [16:0] prev_addr;
    logic [15:0] prev_data;
    do_reset();
    w0 = writes;
    f0 = flushes;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    for (int c = 0; c < 200 && !((writes - w0 == 8) && (flushes - f0 == 1)); c++) begin
      if (c < 8) set_pixel(c + 20, c + 1, 8'(c * 30), 8'(c * 17), 8'(200 - c), 1'b1);
      else write_pixel = 1'b0;
      draw_done = (c == 8);
      mem_ack = (c % 2 == 0);
      if (prev_req && !prev_ack) begin
        checks++;
        if (mem_addr !== prev_addr || mem_data !== prev_data) begin
          failures++;
          $display("FAIL throttle_hold_%0d got=%0d/%h required=%0d/%h", c, mem_addr, mem_data, prev_addr, prev_data);
        end
      end
      if (flush_done) begin
        checks++;
        if (writes - w0 != 8) begin
          failures++;
          $display("FAIL throttle_early_flush got_writes=%0d required=8", writes - w0);
        end
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_data;
      tick();
    end
    idle_inputs();
    checks += 2;
    if (writes - w0 != 8)   begin failures++; $display("FAIL throttle_writes got=%0d required=8", writes - w0); end
    if (flushes - f0 != 1)  begin failures++; $display("FAIL throttle_flushes got=%0d required=1", flushes - f0); end
  endtask

  task automatic test_simul;
    int w0;
    do_reset();
    w0 = writes;
    for (int i = 0; i < 16; i++) begin
      set_pixel(i, 9, 8'(i), 8'(i + 1), 8'(i + 2), 1'b1);
      tick();
    end
    idle_inputs();
    checks++;
    if (level !== 5'd15) begin failures++; $display("FAIL simul_fill got=%0d required=15", level); end
    set_pixel(100, 9, 8'hA0, 8'hB0, 8'hC0, 1'b1);
    mem_ack = 1'b1;
    tick();
    checks += 2;
    if (level !== 5'd15)   begin failures++; $display("FAIL simul_15 got=%0d required=15", level); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL simul_15_ovf got=%b required=0", overflow); end
    set_pixel(101, 9, 8'hA1, 8'hB1, 8'hC1, 1'b1);
    mem_ack = 1'b0;
    tick();
    checks++;
    if (level !== 5'd16) begin failures++; $display("FAIL simul_16 got=%0d required=16", level); end
    set_pixel(102, 9, 8'hA2, 8'hB2, 8'hC2, 1'b0);
    mem_ack = 1'b1;
    tick();
    idle_inputs();
    checks += 2;
    if (level !== 5'd15)   begin failures++; $display("FAIL simul_refuse got=%0d required=15", level); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL simul_ovf got=%b required=1", overflow); end
    wait_drain("simul");
    checks++;
    if (writes - w0 != 18) begin failures++; $display("FAIL simul_writes got=%0d required=18", writes - w0); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_pixel(i + 50, 100, 8'hF0, 8'h0F, 8'h55, 1'b1);
      tick();
    end
    idle_inputs();
    checks += 2;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_req_pre got=%b required=1", mem_req); end
    if (level !== 5'd5)   begin failures++; $display("FAIL mid_level_pre got=%0d required=5", level); end
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    checks += 3;
    if (mem_req !== 1'b0)  begin failures++; $display("FAIL mid_req got=%b required=0", mem_req); end
    if (level !== 5'd0)    begin failures++; $display("FAIL mid_level got=%0d required=0", level); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b required=0", overflow); end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL mid_req_after got=%b required=0", mem_req); end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    checks++;
    if (flush_done !== 1'b1) begin failures++; $display("FAIL mid_flush got=%b required=1", flush_done); end
    tick();
    checks++;
    if (flush_done !== 1'b0) begin failures++; $display("FAIL mid_flush_end got=%b required=0", flush_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clip();
    test_backpressure();
    test_throttle();
    test_simul();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
